// File: rtl/seq_muladd_pkg.sv
// Shared definitions for the shift-add reconstructor: state encodings and default width.
package seq_muladd_pkg;
  localparam int DEF_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_muladd_step.sv
// One shift-add iteration: acc + (bit_en ? divider << shift : 0), purely combinational.
module muladd_step #(
  parameter int BITS = 4,
  parameter int SW   = 2
) (
  input  logic [2*BITS-1:0] acc,
  input  logic [BITS-1:0]   divider,
  input  logic              bit_en,
  input  logic [SW-1:0]     shift,
  output logic [2*BITS-1:0] sum
);
  logic [2*BITS-1:0] addend;

  assign addend = bit_en ? ({{BITS{1'b0}}, divider} << shift) : '0;
  assign sum    = acc + addend;
endmodule

// File: rtl/seq_muladd.sv
// Sequential quotient*divider + modulo, one quotient bit per clock, start/busy/done handshake.
module seq_muladd
  import seq_muladd_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BITS-1:0]   quotient,
  input  logic [BITS-1:0]   divider,
  input  logic [BITS-1:0]   modulo,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] product,
  output logic              err
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_t            state;
  logic [BITS-1:0]   q_lat;
  logic [BITS-1:0]   d_lat;
  logic [2*BITS-1:0] acc;
  logic [2*BITS-1:0] acc_nxt;
  logic [CW-1:0]     idx;
  logic              err_r;

  muladd_step #(.BITS(BITS), .SW(CW)) u_step (
    .acc     (acc),
    .divider (d_lat),
    .bit_en  (q_lat[idx]),
    .shift   (idx),
    .sum     (acc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      q_lat   <= '0;
      d_lat   <= '0;
      acc     <= '0;
      idx     <= '0;
      err_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // DONE accepts a new start exactly like IDLE so back-to-back ops lose no cycle.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            q_lat <= quotient;
            d_lat <= divider;
            acc   <= {{BITS{1'b0}}, modulo};
            idx   <= '0;
            err_r <= (divider == '0) || (modulo >= divider);
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          idx <= idx + CW'(1);
          if (idx == LAST) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= acc_nxt;
            err     <= err_r;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_muladd.sv
// Self-checking bench for seq_muladd: directed plan cases, random ops and an exhaustive divider sweep.
module tb_seq_muladd;
  localparam int BITS = 4;
  localparam int LAT  = BITS + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [BITS-1:0]   quotient = '0;
  logic [BITS-1:0]   divider = '0;
  logic [BITS-1:0]   modulo = '0;
  logic              busy;
  logic              done;
  logic [2*BITS-1:0] product;
  logic              err;

  int passed = 0;
  int total  = 0;

  seq_muladd #(.BITS(BITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .quotient (quotient),
    .divider  (divider),
    .modulo   (modulo),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference: the arithmetic meaning of the operation, nothing about its iteration.
  function automatic int ref_prod(input int q, input int d, input int m);
    return q * d + m;
  endfunction

  function automatic bit ref_err(input int d, input int m);
    return (d == 0) || (m >= d);
  endfunction

  // One operation: start for a single cycle, scramble inputs afterwards, wait for done.
  task automatic run_op(input int q, input int d, input int m,
                        output int p, output bit e, output int lat,
                        output int bcyc, output bit busy_at_done);
    @(negedge clk);
    quotient = BITS'(q); divider = BITS'(d); modulo = BITS'(m); start = 1'b1;
    lat = 0; bcyc = 0; busy_at_done = 1'b0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      quotient = BITS'($urandom); divider = BITS'($urandom); modulo = BITS'($urandom);
      lat++;
      if (busy) bcyc++;
    end while (!done && lat < 20);
    busy_at_done = busy;
    p = int'(product);
    e = err;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy, done, product, err} !== '0) begin
      $display("FAIL reset_state busy=%b done=%b product=%0d err=%b required all 0",
               busy, done, product, err);
    end else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    int qs[4] = '{3, 15, 7, 2};
    int ds[4] = '{5, 15, 0, 5};
    int ms[4] = '{2, 14, 3, 6};
    int p, lat, bc;
    bit e, bd;
    for (int k = 0; k < 4; k++) begin
      run_op(qs[k], ds[k], ms[k], p, e, lat, bc, bd);
      total++;
      if (p !== ref_prod(qs[k], ds[k], ms[k]) || e !== ref_err(ds[k], ms[k])) begin
        $display("FAIL directed_%0d product=%0d err=%b required product=%0d err=%b",
                 k, p, e, ref_prod(qs[k], ds[k], ms[k]), ref_err(ds[k], ms[k]));
      end else passed++;
      total++;
      if (lat !== LAT || bc !== BITS || bd !== 1'b0) begin
        $display("FAIL directed_timing_%0d latency=%0d busy_cycles=%0d busy_at_done=%b required %0d %0d 0",
                 k, lat, bc, bd, LAT, BITS);
      end else passed++;
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || product !== 8'(ref_prod(qs[k], ds[k], ms[k]))) begin
        $display("FAIL done_pulse_hold_%0d done=%b product=%0d required done=0 product=%0d",
                 k, done, product, ref_prod(qs[k], ds[k], ms[k]));
      end else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    int prods[$];
    int cyc = 0;
    @(negedge clk);
    quotient = 4'd1; divider = 4'd1; modulo = 4'd0; start = 1'b1;
    while (done_cyc.size() < 2 && cyc < 30) begin
      @(posedge clk); #1;
      if (done) begin
        done_cyc.push_back(cyc);
        prods.push_back(int'(product));
        if (done_cyc.size() == 1) begin
          quotient = 4'd4; divider = 4'd3; modulo = 4'd2;
        end else start = 1'b0;
      end
      cyc++;
    end
    start = 1'b0;
    total++;
    if (done_cyc.size() != 2) begin
      $display("FAIL b2b_done_count got=%0d required=2", done_cyc.size());
    end else begin
      passed++;
      total++;
      if (done_cyc[0] !== LAT - 1 || done_cyc[1] - done_cyc[0] !== LAT) begin
        $display("FAIL b2b_spacing first=%0d gap=%0d required first=%0d gap=%0d",
                 done_cyc[0], done_cyc[1] - done_cyc[0], LAT - 1, LAT);
      end else passed++;
      total++;
      if (prods[0] !== ref_prod(1, 1, 0) || prods[1] !== ref_prod(4, 3, 2)) begin
        $display("FAIL b2b_products got=%0d,%0d required=%0d,%0d",
                 prods[0], prods[1], ref_prod(1, 1, 0), ref_prod(4, 3, 2));
      end else passed++;
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL b2b_return_idle busy=%b done=%b required 0 0", busy, done);
    end else passed++;
  endtask

  task automatic test_start_in_run();
    int dones = 0;
    int first = -1;
    int p = 0;
    @(negedge clk);
    quotient = 4'd6; divider = 4'd7; modulo = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 14; c++) begin
      if (c == 2) begin
        quotient = 4'd9; divider = 4'd9; modulo = 4'd0; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (first < 0) begin first = c; p = int'(product); end
      end
      @(negedge clk);
    end
    total++;
    if (dones !== 1 || first !== LAT - 1 || p !== ref_prod(6, 7, 1)) begin
      $display("FAIL start_in_run dones=%0d at=%0d product=%0d required 1 at %0d product=%0d",
               dones, first, p, LAT - 1, ref_prod(6, 7, 1));
    end else passed++;
  endtask

  task automatic test_async_reset();
    int p, lat, bc, seen;
    bit e, bd;
    run_op(15, 15, 14, p, e, lat, bc, bd);
    @(negedge clk);
    quotient = 4'd2; divider = 4'd0; modulo = 4'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, product, err} !== '0) begin
      $display("FAIL async_reset busy=%b done=%b product=%0d err=%b required all 0",
               busy, done, product, err);
    end else passed++;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    total++;
    if (seen !== 0) begin
      $display("FAIL no_done_after_reset dones=%0d required=0", seen);
    end else passed++;
    run_op(11, 13, 12, p, e, lat, bc, bd);
    total++;
    if (p !== ref_prod(11, 13, 12) || e !== 1'b0 || lat !== LAT) begin
      $display("FAIL post_reset_op product=%0d err=%b lat=%0d required %0d 0 %0d",
               p, e, lat, ref_prod(11, 13, 12), LAT);
    end else passed++;
  endtask

  task automatic test_random();
    int q, d, m, p, lat, bc;
    bit e, bd;
    for (int k = 0; k < 40; k++) begin
      q = int'($urandom_range(15)); d = int'($urandom_range(15)); m = int'($urandom_range(15));
      run_op(q, d, m, p, e, lat, bc, bd);
      total++;
      if (p !== ref_prod(q, d, m) || e !== ref_err(d, m) || lat !== LAT) begin
        $display("FAIL random q=%0d d=%0d m=%0d product=%0d err=%b lat=%0d required %0d %b %0d",
                 q, d, m, p, e, lat, ref_prod(q, d, m), ref_err(d, m), LAT);
      end else passed++;
    end
  endtask

  // Divider outputs for every dividend/divider pair must rebuild the dividend.
  task automatic test_sweep();
    int p, lat, bc;
    bit e, bd;
    for (int dd = 1; dd < 16; dd++) begin
      for (int n = 0; n < 16; n++) begin
        run_op(n / dd, dd, n % dd, p, e, lat, bc, bd);
        total++;
        if (p !== n || e !== 1'b0) begin
          $display("FAIL sweep n=%0d d=%0d product=%0d err=%b required %0d 0", n, dd, p, e, n);
        end else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_in_run();
    test_async_reset();
    test_random();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seq_muladd.md
# seq_muladd

Sequential shift-add reconstructor, the inverse of the calculator's divider: given a quotient, divider and remainder it produces quotient*divider + remainder, i.e. the original dividend. It serves as the self-check path and as the multiply engine for the calculator datapath. The unit processes one quotient bit per clock behind a start/busy/done handshake, and flags operand sets that no valid division could have produced.

## Interface
- BITS, 4, operand width; product is 2*BITS wide
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when not busy
- quotient  input  BITS  multiplier operand
- divider  input  BITS  multiplicand operand
- modulo  input  BITS  addend (remainder)
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse, result valid
- product  output  2*BITS  quotient*divider + modulo
- err  output  1  operands inconsistent (divider==0 or modulo>=divider), valid with done

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - latch quotient, divider and modulo;
  - acc = zero-extended modulo;
  - bit index i = 0;
  - err_r = (divider==0) | (modulo>=divider);
  - go to RUN.
- RUN, each cycle:
  - if q_lat[i], then acc = acc + (divider_lat << i);
  - i = i + 1;
  - after the iteration with i = BITS-1, go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 here is accepted as in IDLE (back-to-back) and goes to RUN.
  - Otherwise go to IDLE.
- Arithmetic: acc is 2*BITS wide, unsigned, with no overflow possible. Max value is (2^BITS-1)^2 + 2^BITS-1 = 2^(2*BITS) - 2^BITS.
- err does not suppress the computation: product is still quotient*divider + modulo.
- product and err hold their last result until the next DONE. Input changes after the start cycle have no effect.
- start in RUN is ignored: no queueing, no abort.
- Reset (asynchronous, any state, including mid-RUN):
  - state IDLE;
  - busy=0, done=0, product=0, err=0;
  - acc and i cleared.
  - Any in-flight operation is discarded and produces no done.

## Timing
- Edge 0 samples start=1.
- busy=1 during cycles 1..BITS, after edges 0..BITS-1.
- The iteration for bit i completes on edge i+1.
- done=1 and product/err updated in the cycle after edge BITS. Latency is BITS+1 edges from start to done.
- busy=0 while done=1.
- Throughput: one operation per BITS+1 cycles with back-to-back start held high.
- busy and done are registered outputs. There is no combinational path from any input to any output.

## Structure
- Shared include/package:
  - state encodings ST_IDLE, ST_RUN, ST_DONE as localparams;
  - default BITS.
- One natural sub-module, muladd_step: combinational acc + (bit ? divider<<i : 0), parameterised by BITS. It is reused by the divider's future sequential variant.
- Top holds the FSM, counter (clog2(BITS) bits) and operand registers.

## Test plan
- BITS=4, q=3, d=5, m=2, start for 1 cycle -> busy for 4 cycles, then done pulse with product=17, err=0.
- q=15, d=15, m=14 -> product=239, err=0. This is the max-value path with no overflow.
- q=7, d=0, m=3 -> product=3, err=1. Also q=2, d=5, m=6 -> product=16, err=1.
- start held high continuously with operands changing each op (1*1+0, then 4*3+2) -> done every 5 cycles with product=1, then 14. start pulses during busy are ignored.
- rst asserted asynchronously mid-RUN (2 cycles after start) -> busy, done, product and err are 0 immediately. No done follows. A new start after release gives a correct result.
- Exhaustive sweep over all q, d and m with d!=0, m<d: feed the divider's outputs for every dividend/divider pair -> product equals the original dividend and err=0.
